// File: rtl/bsg_dramsim3_arb_pkg.sv
// Shared types and helpers for the DRAMSim3 channel arbiter.
package bsg_dramsim3_arb_pkg;

    // Upper bounds on field widths held in a read-tracking entry.
    localparam int unsigned max_id_width_lp   = 8;
    localparam int unsigned max_addr_width_lp = 64;

    // One outstanding-read tracking entry.
    typedef struct packed {
        logic                         v;
        logic [max_id_width_lp-1:0]   id;
        logic [max_addr_width_lp-1:0] addr;
    } track_entry_s;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_round_robin_arb.sv
// Round-robin grant decision: priority starts one past the last granted index.
module bsg_round_robin_arb
    import bsg_dramsim3_arb_pkg::*;
#(
    parameter  int unsigned inputs_p    = 4,
    localparam int unsigned id_width_lp = id_width(inputs_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   grants_en_i,
    input  logic [inputs_p-1:0]    reqs_i,
    output logic [inputs_p-1:0]    grants_o,
    output logic [id_width_lp-1:0] sel_o,
    output logic                   v_o
);

    logic [id_width_lp-1:0] r_ptr;
    logic [id_width_lp-1:0] w_ptr_next;
    logic [inputs_p-1:0]    w_grants;
    logic [id_width_lp-1:0] w_sel;
    logic                   w_found;

    // Scan requests starting at the pointer, wrapping to index 0.
    always_comb begin
        int unsigned idx;
        w_grants = '0;
        w_sel    = '0;
        w_found  = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < inputs_p; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= inputs_p) begin
                idx = idx - inputs_p;
            end
            if (grants_en_i && !w_found && reqs_i[idx]) begin
                w_found       = 1'b1;
                w_grants[idx] = 1'b1;
                w_sel         = id_width_lp'(idx);
            end
        end
        if (int'(w_sel) == int'(inputs_p) - 1) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_sel + id_width_lp'(1);
        end
    end

    // Advance the priority pointer past each issued grant.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign grants_o = w_grants;
    assign sel_o    = w_sel;
    assign v_o      = w_found;

endmodule

// File: rtl/bsg_dramsim3_channel_arbiter.sv
// Arbitrates several requesters onto one DRAM channel, tracks outstanding reads
// and routes each read return back to the requester that issued it.
module bsg_dramsim3_channel_arbiter
    import bsg_dramsim3_arb_pkg::*;
#(
    parameter  int unsigned num_req_p            = 4,
    parameter  int unsigned channel_addr_width_p = 29,
    parameter  int unsigned max_out_p            = 8,
    localparam int unsigned id_width_lp          = id_width(num_req_p),
    localparam int unsigned out_width_lp         = $clog2(max_out_p + 1),
    localparam int unsigned slot_width_lp        = id_width(max_out_p)
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,
    input  logic [num_req_p-1:0]                           v_i,
    input  logic [num_req_p-1:0]                           write_not_read_i,
    input  logic [num_req_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
    output logic [num_req_p-1:0]                           yumi_o,
    output logic                                           dram_v_o,
    output logic                                           dram_write_not_read_o,
    output logic [channel_addr_width_p-1:0]                dram_ch_addr_o,
    input  logic                                           dram_yumi_i,
    input  logic                                           dram_data_v_i,
    input  logic [channel_addr_width_p-1:0]                dram_data_ch_addr_i,
    output logic [num_req_p-1:0]                           data_v_o,
    output logic [out_width_lp-1:0]                        outstanding_o
);

    logic                            r_v;
    logic                            r_wnr;
    logic [channel_addr_width_p-1:0] r_addr;
    track_entry_s                    r_tab [max_out_p];
    logic [out_width_lp-1:0]         r_count;

    logic                            w_accept;
    logic                            w_full;
    logic                            w_free_found;
    logic [slot_width_lp-1:0]        w_free_idx;
    logic                            w_hit;
    logic [slot_width_lp-1:0]        w_hit_idx;
    logic [num_req_p-1:0]            w_elig;
    logic [num_req_p-1:0]            w_grants;
    logic [id_width_lp-1:0]          w_sel;
    logic                            w_grant_v;
    logic                            w_alloc;
    logic [num_req_p-1:0]            w_data_v;
    track_entry_s                    w_new_entry;
    logic                            w_unused_tab;

    // The output register can take a new request when empty or draining now.
    assign w_accept = ~r_v | dram_yumi_i;
    assign w_full   = (r_count == out_width_lp'(max_out_p));

    // Table lookups: lowest free slot, return match, and the routed return pulse.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_data_v     = '0;
        w_unused_tab = 1'b0;
        for (int unsigned k = 0; k < max_out_p; k++) begin
            w_unused_tab = w_unused_tab ^ (^r_tab[k]);
            if (!r_tab[k].v && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = slot_width_lp'(k);
            end
            if (dram_data_v_i && r_tab[k].v && !w_hit &&
                (r_tab[k].addr[channel_addr_width_p-1:0] == dram_data_ch_addr_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = slot_width_lp'(k);
            end
        end
        if (w_hit) begin
            w_data_v[r_tab[w_hit_idx].id[id_width_lp-1:0]] = 1'b1;
        end
    end

    // Reads need a free slot and no in-flight read to the same address.
    always_comb begin
        logic match;
        w_elig = '0;
        match  = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            match = 1'b0;
            for (int unsigned k = 0; k < max_out_p; k++) begin
                if (r_tab[k].v && (r_tab[k].addr[channel_addr_width_p-1:0] == ch_addr_i[i])) begin
                    match = 1'b1;
                end
            end
            w_elig[i] = v_i[i] & (write_not_read_i[i] | (~w_full & ~match));
        end
    end

    bsg_round_robin_arb #(
        .inputs_p (num_req_p)
    ) u_arb (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .grants_en_i (w_accept & reset_n_i),
        .reqs_i      (w_elig),
        .grants_o    (w_grants),
        .sel_o       (w_sel),
        .v_o         (w_grant_v)
    );

    assign w_alloc = w_grant_v & ~write_not_read_i[w_sel] & w_free_found;

    // Build the entry recorded for a granted read.
    always_comb begin
        w_new_entry                                = '0;
        w_new_entry.v                              = 1'b1;
        w_new_entry.id[id_width_lp-1:0]            = w_sel;
        w_new_entry.addr[channel_addr_width_p-1:0] = ch_addr_i[w_sel];
    end

    // One-entry output register toward the channel.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v    <= 1'b0;
            r_wnr  <= 1'b0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_v <= w_grant_v;
            if (w_grant_v) begin
                r_wnr  <= write_not_read_i[w_sel];
                r_addr <= ch_addr_i[w_sel];
            end
        end
    end

    // Read-tracking table and its occupancy count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < max_out_p; k++) begin
                r_tab[k] <= '0;
            end
            r_count <= '0;
        end else begin
            if (dram_data_v_i && !w_hit) begin
                $error("read return for untracked address %0h", dram_data_ch_addr_i);
            end
            if (w_hit) begin
                r_tab[w_hit_idx].v <= 1'b0;
            end
            if (w_alloc) begin
                r_tab[w_free_idx] <= w_new_entry;
            end
            r_count <= r_count + out_width_lp'(w_alloc) - out_width_lp'(w_hit);
        end
    end

    assign yumi_o                = w_grants;
    assign dram_v_o              = r_v;
    assign dram_write_not_read_o = r_wnr;
    assign dram_ch_addr_o        = r_addr;
    assign data_v_o              = w_data_v;
    assign outstanding_o         = r_count;

endmodule

// File: tb/tb_bsg_dramsim3_channel_arbiter.sv
// Scoreboard bench for the DRAMSim3 channel arbiter.
module tb_bsg_dramsim3_channel_arbiter;

    localparam int NR = 4;
    localparam int AW = 29;
    localparam int MO = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        v_i = '0;
    logic [NR-1:0]        wnr_i = '0;
    logic [NR-1:0][AW-1:0] addr_i = '0;
    logic [NR-1:0]        yumi;
    logic                 dram_v;
    logic                 dram_wnr;
    logic [AW-1:0]        dram_addr;
    logic                 dram_yumi = 1'b0;
    logic                 ddv = 1'b0;
    logic [AW-1:0]        ddaddr = '0;
    logic [NR-1:0]        data_v;
    logic [3:0]           outst;

    always #5 clk = ~clk;

    bsg_dramsim3_channel_arbiter #(
        .num_req_p            (NR),
        .channel_addr_width_p (AW),
        .max_out_p            (MO)
    ) dut (
        .clk_i                 (clk),
        .reset_n_i             (rst_n),
        .v_i                   (v_i),
        .write_not_read_i      (wnr_i),
        .ch_addr_i             (addr_i),
        .yumi_o                (yumi),
        .dram_v_o              (dram_v),
        .dram_write_not_read_o (dram_wnr),
        .dram_ch_addr_o        (dram_addr),
        .dram_yumi_i           (dram_yumi),
        .dram_data_v_i         (ddv),
        .dram_data_ch_addr_i   (ddaddr),
        .data_v_o              (data_v),
        .outstanding_o         (outst)
    );

    typedef struct {bit wnr; logic [AW-1:0] addr;} req_t;
    typedef struct {int id; logic [AW-1:0] addr;} ent_t;

    req_t sb[$];      // requests granted but not yet taken by the channel
    ent_t outs[$];    // reads in flight, in issue order
    int   m_ptr;      // next requester with top priority
    bit   m_full;     // model of output register occupancy

    int n_vec = 0;
    int n_err = 0;
    bit done = 0;

    logic [NR-1:0] s_v, s_wnr;
    logic [AW-1:0] s_addr [NR];
    logic          s_dy, s_dv;
    logic [AW-1:0] s_da;
    logic [NR-1:0] c_yumi, c_dv;
    logic [3:0]    c_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_flight(input logic [AW-1:0] a);
        foreach (outs[k]) if (outs[k].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus plus model prediction; returns the granted index or -1.
    task automatic step(output int g);
        int fi;
        logic [NR-1:0] ey, edv;
        bit elig;
        @(negedge clk);
        v_i = s_v; wnr_i = s_wnr; dram_yumi = s_dy; ddv = s_dv; ddaddr = s_da;
        for (int i = 0; i < NR; i++) addr_i[i] = s_addr[i];
        #1;
        fi = -1; edv = '0;
        if (s_dv) begin
            for (int k = 0; k < outs.size(); k++)
                if (fi < 0 && outs[k].addr == s_da) fi = k;
            if (fi >= 0) edv[outs[fi].id] = 1'b1;
        end
        g = -1;
        if (!m_full || s_dy) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                elig = s_v[i] && (s_wnr[i] || (outs.size() < MO && !in_flight(s_addr[i])));
                if (g < 0 && elig) g = i;
            end
        end
        ey = '0;
        if (g >= 0) ey[g] = 1'b1;
        c_yumi = yumi; c_dv = data_v; c_out = outst;
        chk("yumi", 32'(yumi), 32'(ey));
        chk("data_v", 32'(data_v), 32'(edv));
        chk("outstanding", 32'(outst), 32'(outs.size()));
        @(posedge clk);
        if (fi >= 0) outs.delete(fi);
        if (g >= 0) begin
            req_t r;
            r.wnr = s_wnr[g]; r.addr = s_addr[g];
            sb.push_back(r);
            if (!s_wnr[g]) begin
                ent_t e;
                e.id = g; e.addr = s_addr[g];
                outs.push_back(e);
            end
            m_ptr = (g + 1) % NR;
        end
        m_full = (g >= 0) ? 1'b1 : (s_dy ? 1'b0 : m_full);
    endtask

    task automatic drain();
        int g;
        s_v = '0; s_dy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (outs.size() != 0) begin s_dv = 1'b1; s_da = outs[0].addr; end
            else s_dv = 1'b0;
            step(g);
        end
        s_dv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; v_i = '1; wnr_i = '0; ddv = 1'b0;
        sb.delete(); outs.delete(); m_ptr = 0; m_full = 1'b0;
        #1;
        chk("rst_yumi", 32'(yumi), 0);
        chk("rst_data_v", 32'(data_v), 0);
        chk("rst_dram_v", 32'(dram_v), 0);
        chk("rst_outstanding", 32'(outst), 0);
        @(negedge clk); #1;
        chk("rst_yumi_hold", 32'(yumi), 0);
        v_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the channel request is presented, compare against the scoreboard head.
    initial begin
        while (!done) begin
            @(negedge clk); #2;
            chk("dram_v", 32'(dram_v), 32'(sb.size() != 0));
            if (dram_v && sb.size() != 0) begin
                chk("dram_addr", 32'(dram_addr), 32'(sb[0].addr));
                chk("dram_wnr", 32'(dram_wnr), 32'(sb[0].wnr));
                if (dram_yumi) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int g, n;
        s_v = '0; s_wnr = '0; s_dy = 1'b0; s_dv = 1'b0; s_da = '0;
        for (int i = 0; i < NR; i++) s_addr[i] = '0;
        do_reset();

        // All four read distinct addresses: grants 0,1,2,3 back to back.
        s_v = 4'hF; s_wnr = '0; s_dy = 1'b1;
        for (int i = 0; i < NR; i++) s_addr[i] = 29'h100 + 29'(i);
        for (int k = 0; k < NR; k++) begin
            step(g);
            chk("rr_order", 32'(c_yumi), 32'(1 << k));
            if (g >= 0) s_v[g] = 1'b0;
        end
        drain();

        // Channel stall: request held, nothing granted for five cycles.
        s_v = 4'b0001; s_wnr = '0; s_addr[0] = 29'h300; s_dy = 1'b0;
        step(g);
        s_v = 4'b0110; s_wnr = 4'b0110; s_addr[1] = 29'h310; s_addr[2] = 29'h320;
        for (int k = 0; k < 5; k++) begin
            step(g);
            chk("stall_yumi", 32'(c_yumi), 0);
        end
        s_dy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(g);
            if (g >= 0) s_v[g] = 1'b0;
        end
        drain();

        // Fill the table with reads; the ninth stalls, a write still goes.
        s_v = 4'b0001; s_wnr = '0; s_dy = 1'b1; n = 0; s_addr[0] = 29'h400;
        for (int k = 0; k < 12; k++) begin
            step(g);
            if (g == 0) begin n++; s_addr[0] = 29'h400 + 29'(n); end
        end
        chk("ninth_stall", 32'(c_yumi), 0);
        chk("sat_cnt", 32'(c_out), 8);
        s_v = 4'b0011; s_wnr = 4'b0010; s_addr[1] = 29'h4F0;
        step(g);
        chk("write_at_full", 32'(c_yumi), 2);
        s_v = 4'b0001; s_wnr = '0;

        // Return while full with a read waiting: slot reused only next cycle.
        s_dv = 1'b1; s_da = 29'h400;
        step(g);
        chk("ret_full_yumi", 32'(c_yumi), 0);
        chk("ret_full_dv", 32'(c_dv), 1);
        s_dv = 1'b0;
        step(g);
        chk("reuse_yumi", 32'(c_yumi), 1);
        s_v = '0;
        step(g);
        chk("reuse_cnt", 32'(c_out), 8);
        drain();

        // Two requesters read the same address: the second waits for the return.
        s_v = 4'b0110; s_wnr = '0; s_addr[1] = 29'h40; s_addr[2] = 29'h40; s_dy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(g);
            if (g >= 0) s_v[g] = 1'b0;
        end
        chk("dup_stall", 32'(c_yumi), 0);
        s_dv = 1'b1; s_da = 29'h40;
        step(g);
        chk("dup_ret_dv", 32'(c_dv), 2);
        s_dv = 1'b0;
        step(g);
        chk("dup_grant2", 32'(c_yumi), 4);
        s_v = '0;
        drain();

        // Randomized traffic with address collisions and random channel back-pressure.
        for (int k = 0; k < 400; k++) begin
            s_v = NR'($urandom); s_wnr = NR'($urandom);
            for (int i = 0; i < NR; i++) s_addr[i] = 29'h500 + 29'($urandom_range(0, 11));
            s_dy = ($urandom_range(0, 3) != 0);
            if (outs.size() != 0 && $urandom_range(0, 2) == 0) begin
                s_dv = 1'b1;
                s_da = outs[$urandom_range(0, outs.size() - 1)].addr;
            end else s_dv = 1'b0;
            step(g);
        end
        s_dv = 1'b0;
        drain();

        // Reset with three reads outstanding.
        s_v = 4'b0111; s_wnr = '0; s_dy = 1'b1;
        for (int i = 0; i < NR; i++) s_addr[i] = 29'h600 + 29'(i);
        for (int k = 0; k < 4; k++) begin
            step(g);
            if (g >= 0) s_v[g] = 1'b0;
        end
        chk("pre_rst_cnt", 32'(c_out), 3);
        do_reset();
        s_v = '0; s_dv = 1'b0;
        step(g);
        chk("post_rst_cnt", 32'(c_out), 0);
        s_v = 4'b0001; s_addr[0] = 29'h700;
        step(g);
        chk("post_rst_grant", 32'(c_yumi), 1);
        drain();

        done = 1'b1;
        @(negedge clk); #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_dramsim3_channel_arbiter.md
BSG_DRAMSIM3_CHANNEL_ARBITER -- requirements
Module: bsg_dramsim3_channel_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 4, number of requesters sharing one DRAM channel.
REQ-002 SHALL have parameter channel_addr_width_p, default 29, channel address width.
REQ-003 SHALL have parameter max_out_p, default 8, number of read-tracking table entries.
REQ-004 SHALL have port clk_i, input, 1, the only clock.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port v_i, input, num_req_p, per-requester request valid.
REQ-007 SHALL have port write_not_read_i, input, num_req_p, per-requester 1=write, 0=read.
REQ-008 SHALL have port ch_addr_i, input, num_req_p x channel_addr_width_p, per-requester address.
REQ-009 SHALL have port yumi_o, output, num_req_p, one-hot request accept.
REQ-010 SHALL have port dram_v_o, input-facing output, 1, channel request valid.
REQ-011 SHALL have ports dram_write_not_read_o (output, 1) and dram_ch_addr_o (output, channel_addr_width_p), carrying the registered request.
REQ-012 SHALL have port dram_yumi_i, input, 1, channel accepts the request.
REQ-013 SHALL have ports dram_data_v_i (input, 1) and dram_data_ch_addr_i (input, channel_addr_width_p), read-return event and its address.
REQ-014 SHALL have port data_v_o, output, num_req_p, one-hot routed read-return pulse.
REQ-015 SHALL have port outstanding_o, output, $clog2(max_out_p+1), count of valid table entries.

Function
REQ-016 SHALL hold the granted request in a one-entry output register; dram_v_o = register valid; contents stable while dram_v_o & ~dram_yumi_i.
REQ-017 SHALL grant at most one requester per cycle, only when register empty or dram_yumi_i is high that cycle (back-to-back issue allowed).
REQ-018 SHALL treat a requester as eligible when v_i is high and, for reads, a free table entry exists and no valid entry holds an equal address.
REQ-019 SHALL choose among eligible requesters round-robin, starting one past the last granted index, wrapping num_req_p-1 -> 0.
REQ-020 SHALL assert yumi_o[i] in the grant cycle; dram_v_o rises the next cycle (latency 1).
REQ-021 SHALL allocate the lowest-index free table entry {valid, requester id, address} in the read-grant cycle; writes allocate nothing.
REQ-022 SHALL, on dram_data_v_i, free the matching valid entry and pulse data_v_o[id] in the same cycle (combinational route).
REQ-023 SHALL, when return and allocation occur in the same cycle, make the freed entry reusable the next cycle, not the same cycle; outstanding_o = old + alloc - free.
REQ-024 SHALL flag an error via $error and leave the table unchanged when dram_data_v_i matches no valid entry.
REQ-025 SHALL make no request eligible for reads when outstanding_o == max_out_p; writes remain eligible.

Reset
REQ-026 SHALL, while reset_n_i is low, force register valid, all table entries, yumi_o, data_v_o, and outstanding_o to 0, and reset the round-robin pointer to requester 0.
REQ-027 SHALL drop any in-flight request and tracked reads on reset mid-operation; a later return is then unmatched (REQ-024).
REQ-028 SHALL deassert reset asynchronously-asserted, synchronously-released, with the first grant possible on the first clk_i edge after release.

Structure
REQ-029 SHALL place the tracking-entry struct and the id-width function in package bsg_dramsim3_arb_pkg.
REQ-030 SHALL use bsg_round_robin_arb as the single sub-module for the grant decision.

Verification
REQ-031 SHALL cover: all 4 requesters read distinct addresses, dram_yumi_i=1 -> grants 0,1,2,3 on consecutive cycles, dram_v_o one cycle later each.
REQ-032 SHALL cover: dram_yumi_i=0 for 5 cycles -> dram_ch_addr_o stable, no yumi_o during the stall.
REQ-033 SHALL cover: 9 reads with max_out_p=8 and no returns -> outstanding_o saturates at 8, 9th read stalls, a write still issues.
REQ-034 SHALL cover: requesters 1 and 2 read address 0x40 -> requester 2 stalls until 0x40 returns and data_v_o[1] pulses.
REQ-035 SHALL cover: return and new read in the same cycle at full table -> outstanding_o stays 8, new read issues the next cycle.
REQ-036 SHALL cover: reset_n_i low with 3 outstanding reads -> all outputs 0 within the reset period, outstanding_o=0 after release.
